// File: rtl/lc3_control_unit.sv
// eLC-3 control unit: Moore FSM that sequences fetch/decode/execute and drives
// every datapath load, bus gate, mux select and RAM strobe from registered outputs.
module lc3_control_unit #(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] IR_15_12,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_REG,
   output logic       LD_CC,
   output logic       LD_PC,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] PCMUX,
   output logic [1:0] DRMUX,
   output logic [1:0] SR1MUX,
   output logic       SR2MUX,
   output logic       MARMUX,
   output logic [1:0] ALUK,
   output logic       MIO_EN,
   output logic       Mem_RE,
   output logic       Mem_WE,
   output logic       Halted
);

   localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   localparam int B_LD_MAR = 27, B_LD_MDR = 26, B_LD_IR = 25, B_LD_BEN = 24;
   localparam int B_LD_REG = 23, B_LD_CC = 22, B_LD_PC = 21, B_G_PC = 20;
   localparam int B_G_MDR = 19, B_G_ALU = 18, B_G_MM = 17, B_A1 = 16;
   localparam int B_A2 = 14, B_PCM = 12, B_DRM = 10, B_SR1 = 8, B_SR2 = 7;
   localparam int B_MARM = 6, B_ALUK = 4, B_MIO = 3, B_RE = 2, B_WE = 1, B_HALT = 0;

   typedef enum logic [4:0] {
      S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_ADD, S_AND, S_NOT, S_BR1, S_BR_TAKEN, S_JMP,
      S_JSR1, S_JSR2_OFF, S_JSR2_REG,
      S_LDR_ADDR, S_STR_ADDR, S_LD_ADDR, S_ST_ADDR,
      S_MEMRD, S_WB, S_ST_MDR, S_MEMWR, S_LEA, S_PAUSE1, S_PAUSE2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   w_wait_next;
   logic                r_cont_q;
   logic [27:0]         r_out;
   logic                w_mem_state;
   logic                w_wait_done;
   logic                w_cont_rise;

   // Output word for the state being entered; registering it keeps outputs glitch-free.
   function automatic logic [27:0] f_decode(input state_t s, input logic ir5);
      logic [27:0] o;
      o = '0;
      case (s)
         S_HALTED:   o[B_HALT] = 1'b1;
         S_FETCH1:   begin o[B_G_PC] = 1'b1; o[B_LD_MAR] = 1'b1; o[B_LD_PC] = 1'b1; end
         S_FETCH2,
         S_MEMRD:    begin o[B_RE] = 1'b1; o[B_MIO] = 1'b1; o[B_LD_MDR] = 1'b1; end
         S_FETCH3:   begin o[B_G_MDR] = 1'b1; o[B_LD_IR] = 1'b1; end
         S_DECODE:   o[B_LD_BEN] = 1'b1;
         S_ADD, S_AND, S_NOT: begin
            o[B_SR1 +: 2] = 2'd1;
            o[B_SR2]      = (s == S_NOT) ? 1'b0 : ir5;
            o[B_ALUK +: 2] = (s == S_ADD) ? 2'd0 : (s == S_AND) ? 2'd1 : 2'd2;
            o[B_G_ALU] = 1'b1; o[B_LD_REG] = 1'b1; o[B_LD_CC] = 1'b1;
         end
         S_BR_TAKEN: begin o[B_A2 +: 2] = 2'd2; o[B_PCM +: 2] = 2'd2; o[B_LD_PC] = 1'b1; end
         S_JMP, S_JSR2_REG: begin
            o[B_SR1 +: 2] = 2'd1; o[B_A1] = 1'b1;
            o[B_PCM +: 2] = 2'd2; o[B_LD_PC] = 1'b1;
         end
         S_JSR1:     begin o[B_G_PC] = 1'b1; o[B_DRM +: 2] = 2'd1; o[B_LD_REG] = 1'b1; end
         S_JSR2_OFF: begin o[B_A2 +: 2] = 2'd3; o[B_PCM +: 2] = 2'd2; o[B_LD_PC] = 1'b1; end
         S_LDR_ADDR, S_STR_ADDR: begin
            o[B_SR1 +: 2] = 2'd1; o[B_A1] = 1'b1; o[B_A2 +: 2] = 2'd1;
            o[B_MARM] = 1'b1; o[B_G_MM] = 1'b1; o[B_LD_MAR] = 1'b1;
         end
         S_LD_ADDR, S_ST_ADDR: begin
            o[B_A2 +: 2] = 2'd2; o[B_MARM] = 1'b1; o[B_G_MM] = 1'b1; o[B_LD_MAR] = 1'b1;
         end
         S_WB:       begin o[B_G_MDR] = 1'b1; o[B_LD_REG] = 1'b1; o[B_LD_CC] = 1'b1; end
         S_ST_MDR:   begin o[B_ALUK +: 2] = 2'd3; o[B_G_ALU] = 1'b1; o[B_LD_MDR] = 1'b1; end
         S_MEMWR:    o[B_WE] = 1'b1;
         S_LEA: begin
            o[B_A2 +: 2] = 2'd2; o[B_MARM] = 1'b1; o[B_G_MM] = 1'b1;
            o[B_LD_REG] = 1'b1; o[B_LD_CC] = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

   assign w_mem_state = (r_state == S_FETCH2) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_wait_done = (r_wait == WAIT_W'(MEM_WAIT - 1));
   assign w_cont_rise = Continue & ~r_cont_q;
   assign w_wait_next = (w_mem_state && !w_wait_done) ? r_wait + WAIT_W'(1) : '0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HALTED:  if (Run) w_next = S_FETCH1;
         S_FETCH1:  w_next = S_FETCH2;
         S_FETCH2:  if (w_wait_done) w_next = S_FETCH3;
         S_FETCH3:  w_next = S_DECODE;
         S_DECODE: begin
            case (IR_15_12)
               4'b0001: w_next = S_ADD;
               4'b0101: w_next = S_AND;
               4'b1001: w_next = S_NOT;
               4'b0000: w_next = S_BR1;
               4'b1100: w_next = S_JMP;
               4'b0100: w_next = S_JSR1;
               4'b0110: w_next = S_LDR_ADDR;
               4'b0111: w_next = S_STR_ADDR;
               4'b0010: w_next = S_LD_ADDR;
               4'b0011: w_next = S_ST_ADDR;
               4'b1110: w_next = S_LEA;
               4'b1101: w_next = S_PAUSE1;
               default: w_next = S_FETCH1;
            endcase
         end
         S_BR1:      w_next = BEN ? S_BR_TAKEN : S_FETCH1;
         S_JSR1:     w_next = IR_11 ? S_JSR2_OFF : S_JSR2_REG;
         S_LDR_ADDR, S_LD_ADDR: w_next = S_MEMRD;
         S_STR_ADDR, S_ST_ADDR: w_next = S_ST_MDR;
         S_MEMRD:    if (w_wait_done) w_next = S_WB;
         S_ST_MDR:   w_next = S_MEMWR;
         S_MEMWR:    if (w_wait_done) w_next = S_FETCH1;
         // Continue held high on entry must be released and re-pressed to resume.
         S_PAUSE1:   if (w_cont_rise) w_next = S_PAUSE2;
         S_PAUSE2:   if (!Continue) w_next = S_FETCH1;
         S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2_OFF, S_JSR2_REG, S_WB, S_LEA:
                     w_next = S_FETCH1;
         default:    w_next = S_HALTED;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= S_HALTED;
         r_wait   <= '0;
         r_cont_q <= 1'b0;
         r_out    <= 28'd1 << B_HALT;
      end else begin
         r_state  <= w_next;
         r_wait   <= w_wait_next;
         r_cont_q <= Continue;
         r_out    <= f_decode(w_next, IR_5);
      end
   end

   assign LD_MAR     = r_out[B_LD_MAR];
   assign LD_MDR     = r_out[B_LD_MDR];
   assign LD_IR      = r_out[B_LD_IR];
   assign LD_BEN     = r_out[B_LD_BEN];
   assign LD_REG     = r_out[B_LD_REG];
   assign LD_CC      = r_out[B_LD_CC];
   assign LD_PC      = r_out[B_LD_PC];
   assign GatePC     = r_out[B_G_PC];
   assign GateMDR    = r_out[B_G_MDR];
   assign GateALU    = r_out[B_G_ALU];
   assign GateMARMUX = r_out[B_G_MM];
   assign ADDR1MUX   = r_out[B_A1];
   assign ADDR2MUX   = r_out[B_A2 +: 2];
   assign PCMUX      = r_out[B_PCM +: 2];
   assign DRMUX      = r_out[B_DRM +: 2];
   assign SR1MUX     = r_out[B_SR1 +: 2];
   assign SR2MUX     = r_out[B_SR2];
   assign MARMUX     = r_out[B_MARM];
   assign ALUK       = r_out[B_ALUK +: 2];
   assign MIO_EN     = r_out[B_MIO];
   assign Mem_RE     = r_out[B_RE];
   assign Mem_WE     = r_out[B_WE];
   assign Halted     = r_out[B_HALT];

endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: per-instruction output sequences from a vector table,
// plus hand-written reset, PAUSE and MEM_WAIT=3 store sequences.
module tb_lc3_control_unit;

   typedef logic [27:0] ow_t;

   localparam ow_t LDMAR = 28'd1 << 27, LDMDR = 28'd1 << 26, LDIR  = 28'd1 << 25;
   localparam ow_t LDBEN = 28'd1 << 24, LDREG = 28'd1 << 23, LDCC  = 28'd1 << 22;
   localparam ow_t LDPC  = 28'd1 << 21, GPC   = 28'd1 << 20, GMDR  = 28'd1 << 19;
   localparam ow_t GALU  = 28'd1 << 18, GMM   = 28'd1 << 17, A1    = 28'd1 << 16;
   localparam ow_t A2_1  = 28'd1 << 14, A2_2  = 28'd2 << 14, A2_3  = 28'd3 << 14;
   localparam ow_t PCM2  = 28'd2 << 12, DRM1  = 28'd1 << 10, SR1_1 = 28'd1 << 8;
   localparam ow_t SR2   = 28'd1 << 7,  MARM  = 28'd1 << 6;
   localparam ow_t ALU1  = 28'd1 << 4,  ALU2  = 28'd2 << 4,  ALU3  = 28'd3 << 4;
   localparam ow_t MIO   = 28'd1 << 3,  RE    = 28'd1 << 2,  WE    = 28'd1 << 1;
   localparam ow_t HLT   = 28'd1;

   localparam ow_t F1 = GPC | LDMAR | LDPC;
   localparam ow_t F2 = RE | MIO | LDMDR;
   localparam ow_t F3 = GMDR | LDIR;
   localparam ow_t DEC = LDBEN;
   localparam ow_t ALU_R = SR1_1 | GALU | LDREG | LDCC;
   localparam ow_t NOTW = SR1_1 | ALU2 | GALU | LDREG | LDCC;
   localparam ow_t BRT = A2_2 | PCM2 | LDPC;
   localparam ow_t JMPW = SR1_1 | A1 | PCM2 | LDPC;
   localparam ow_t JSR1 = GPC | DRM1 | LDREG;
   localparam ow_t JSR2O = A2_3 | PCM2 | LDPC;
   localparam ow_t JSR2R = SR1_1 | A1 | PCM2 | LDPC;
   localparam ow_t RADDR = SR1_1 | A1 | A2_1 | MARM | GMM | LDMAR;
   localparam ow_t PADDR = A2_2 | MARM | GMM | LDMAR;
   localparam ow_t WBW = GMDR | LDREG | LDCC;
   localparam ow_t STMDR = ALU3 | GALU | LDMDR;
   localparam ow_t LEAW = A2_2 | MARM | GMM | LDREG | LDCC;

   typedef struct {
      string        nm;
      logic [3:0]   op;
      logic         ir5;
      logic         ir11;
      logic         ben;
      int           n;
      ow_t [4:0]    e;
   } vec_t;

   logic Clk, Reset, Run, Continue, IR_5, IR_11, BEN;
   logic [3:0] IR_15_12;

   logic a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_ben, a_ld_reg, a_ld_cc, a_ld_pc;
   logic a_gpc, a_gmdr, a_galu, a_gmm, a_a1, a_sr2, a_marm, a_mio, a_re, a_we, a_halt;
   logic [1:0] a_a2, a_pcm, a_drm, a_sr1, a_aluk;
   logic b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_ben, b_ld_reg, b_ld_cc, b_ld_pc;
   logic b_gpc, b_gmdr, b_galu, b_gmm, b_a1, b_sr2, b_marm, b_mio, b_re, b_we, b_halt;
   logic [1:0] b_a2, b_pcm, b_drm, b_sr1, b_aluk;

   ow_t w2, w3;
   int compared = 0;
   int mism = 0;
   ow_t exp_q[$];
   vec_t vecs[$];

   lc3_control_unit #(.MEM_WAIT(2)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .IR_15_12(IR_15_12), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(a_ld_mar), .LD_MDR(a_ld_mdr), .LD_IR(a_ld_ir), .LD_BEN(a_ld_ben),
      .LD_REG(a_ld_reg), .LD_CC(a_ld_cc), .LD_PC(a_ld_pc),
      .GatePC(a_gpc), .GateMDR(a_gmdr), .GateALU(a_galu), .GateMARMUX(a_gmm),
      .ADDR1MUX(a_a1), .ADDR2MUX(a_a2), .PCMUX(a_pcm), .DRMUX(a_drm),
      .SR1MUX(a_sr1), .SR2MUX(a_sr2), .MARMUX(a_marm), .ALUK(a_aluk),
      .MIO_EN(a_mio), .Mem_RE(a_re), .Mem_WE(a_we), .Halted(a_halt));

   lc3_control_unit #(.MEM_WAIT(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .IR_15_12(IR_15_12), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(b_ld_mar), .LD_MDR(b_ld_mdr), .LD_IR(b_ld_ir), .LD_BEN(b_ld_ben),
      .LD_REG(b_ld_reg), .LD_CC(b_ld_cc), .LD_PC(b_ld_pc),
      .GatePC(b_gpc), .GateMDR(b_gmdr), .GateALU(b_galu), .GateMARMUX(b_gmm),
      .ADDR1MUX(b_a1), .ADDR2MUX(b_a2), .PCMUX(b_pcm), .DRMUX(b_drm),
      .SR1MUX(b_sr1), .SR2MUX(b_sr2), .MARMUX(b_marm), .ALUK(b_aluk),
      .MIO_EN(b_mio), .Mem_RE(b_re), .Mem_WE(b_we), .Halted(b_halt));

   assign w2 = {a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_ben, a_ld_reg, a_ld_cc, a_ld_pc,
                a_gpc, a_gmdr, a_galu, a_gmm, a_a1, a_a2, a_pcm, a_drm, a_sr1,
                a_sr2, a_marm, a_aluk, a_mio, a_re, a_we, a_halt};
   assign w3 = {b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_ben, b_ld_reg, b_ld_cc, b_ld_pc,
                b_gpc, b_gmdr, b_galu, b_gmm, b_a1, b_a2, b_pcm, b_drm, b_sr1,
                b_sr2, b_marm, b_aluk, b_mio, b_re, b_we, b_halt};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input ow_t act, input ow_t exp);
      compared++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %07h, required %07h", nm, act, exp);
      end
   endtask

   // Bus contention watchdog on both instances.
   always @(negedge Clk) begin
      if (!Reset) begin
         compared++;
         if (($countones({a_gpc, a_gmdr, a_galu, a_gmm}) > 1) ||
             ($countones({b_gpc, b_gmdr, b_galu, b_gmm}) > 1)) begin
            mism++;
            $display("FAIL gate_onehot: got %b/%b, required at most one gate",
                     {a_gpc, a_gmdr, a_galu, a_gmm}, {b_gpc, b_gmdr, b_galu, b_gmm});
         end
      end
   end

   task automatic play(input string nm, input bit sel3);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge Clk);
         chk($sformatf("%s[%0d]", nm, i), sel3 ? w3 : w2, exp_q[i]);
      end
   endtask

   function automatic vec_t mkv(input string nm, input logic [3:0] op, input logic ir5,
                                input logic ir11, input logic ben, input int n,
                                input ow_t e0, input ow_t e1, input ow_t e2, input ow_t e3);
      vec_t v;
      v.nm = nm; v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.n = n;
      v.e = {28'd0, e3, e2, e1, e0};
      return v;
   endfunction

   initial begin
      Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
      IR_15_12 = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

      vecs.push_back(mkv("add_imm", 4'b0001, 1, 0, 0, 1, ALU_R | SR2, 0, 0, 0));
      vecs.push_back(mkv("add_reg", 4'b0001, 0, 0, 0, 1, ALU_R, 0, 0, 0));
      vecs.push_back(mkv("and_reg", 4'b0101, 0, 0, 0, 1, ALU_R | ALU1, 0, 0, 0));
      vecs.push_back(mkv("and_imm", 4'b0101, 1, 0, 0, 1, ALU_R | ALU1 | SR2, 0, 0, 0));
      vecs.push_back(mkv("not", 4'b1001, 0, 0, 0, 1, NOTW, 0, 0, 0));
      vecs.push_back(mkv("br_nt", 4'b0000, 0, 0, 0, 1, 28'd0, 0, 0, 0));
      vecs.push_back(mkv("br_t", 4'b0000, 0, 0, 1, 2, 28'd0, BRT, 0, 0));
      vecs.push_back(mkv("jmp", 4'b1100, 0, 0, 0, 1, JMPW, 0, 0, 0));
      vecs.push_back(mkv("jsr", 4'b0100, 0, 1, 0, 2, JSR1, JSR2O, 0, 0));
      vecs.push_back(mkv("jsrr", 4'b0100, 0, 0, 0, 2, JSR1, JSR2R, 0, 0));
      vecs.push_back(mkv("ldr", 4'b0110, 0, 0, 0, 4, RADDR, F2, F2, WBW));
      vecs.push_back(mkv("str", 4'b0111, 0, 0, 0, 4, RADDR, STMDR, WE, WE));
      vecs.push_back(mkv("ld", 4'b0010, 0, 0, 0, 4, PADDR, F2, F2, WBW));
      vecs.push_back(mkv("st", 4'b0011, 0, 0, 0, 4, PADDR, STMDR, WE, WE));
      vecs.push_back(mkv("lea", 4'b1110, 0, 0, 0, 1, LEAW, 0, 0, 0));
      vecs.push_back(mkv("undef8", 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv("undefF", 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset state, then HALTED holds while Run=0.
      @(negedge Clk);
      chk("reset_a", w2, HLT);
      chk("reset_b", w3, HLT);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk($sformatf("halt_hold[%0d]", i), w2, HLT);
      end
      Run = 1'b1;
      @(negedge Clk);
      chk("run_fetch1", w2, F1);

      foreach (vecs[k]) begin
         IR_15_12 = vecs[k].op; IR_5 = vecs[k].ir5; IR_11 = vecs[k].ir11; BEN = vecs[k].ben;
         exp_q = {F2, F2, F3, DEC};
         for (int j = 0; j < vecs[k].n; j++) exp_q.push_back(vecs[k].e[j]);
         exp_q.push_back(F1);
         play(vecs[k].nm, 1'b0);
      end

      // PAUSE: Continue already high on entry must not release it.
      IR_15_12 = 4'b1101; Continue = 1'b1;
      exp_q = {F2, F2, F3, DEC, 28'd0, 28'd0, 28'd0, 28'd0};
      play("pause_held", 1'b0);
      Continue = 1'b0;
      @(negedge Clk); chk("pause_low", w2, 28'd0);
      Continue = 1'b1;
      @(negedge Clk); chk("pause2_a", w2, 28'd0);
      @(negedge Clk); chk("pause2_b", w2, 28'd0);
      IR_15_12 = 4'b0001; IR_5 = 1'b0; Continue = 1'b0;
      @(negedge Clk); chk("pause_exit", w2, F1);

      // Reset asserted mid-read drops the strobe without waiting for a clock edge.
      @(negedge Clk); chk("pre_rst_f2", w2, F2);
      #2 Reset = 1'b1;
      #1 chk("rst_async_a", w2, HLT);
      chk("rst_async_b", w3, HLT);
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk); chk("rst_run_fetch1", w2, F1);

      // Store on the MEM_WAIT=3 instance.
      Reset = 1'b1; IR_15_12 = 4'b0111;
      @(negedge Clk); Reset = 1'b0;
      @(negedge Clk); chk("mw3_fetch1", w3, F1);
      exp_q = {F2, F2, F2, F3, DEC, RADDR, STMDR, WE, WE, WE, F1};
      play("mw3_str", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
